// File: rtl/reg_file_sb_pkg.sv
// Shared MIPS register-file constants: default widths, the hardwired zero register, and register names.
// Pure declarations: no logic, no latency, no flow control.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] SP       = 5'd29;
  localparam logic [4:0] RA       = 5'd31;

  function automatic logic is_zero_reg(input logic [4:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register pending-write bits. Set on issue (seen next cycle), cleared on writeback (seen same cycle via bypass).
// No backpressure: one issue and one writeback are accepted every cycle.
module busy_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first, then set: a producer issuing on the writeback cycle keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en && wr_addr != '0) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_en && issue_addr != '0) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_a = (rd_addr_a != '0) && busy_q[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a);
    busy_b = (rd_addr_b != '0) && busy_q[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b);
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// MIPS 32-entry register file with two bypassed combinational read ports, one write port and a busy scoreboard.
// Reads are 0-cycle (write data forwarded); writes land at the edge; no backpressure.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic                 busy_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 busy_b,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != REG_ZERO) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 reads zero even if a stale write ever reached its slot; forwarding never targets r0.
  always_comb begin
    if (rd_addr_a == REG_ZERO) begin
      rd_data_a = '0;
    end else if (wr_en && wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_q[rd_addr_a];
    end

    if (rd_addr_b == REG_ZERO) begin
      rd_data_b = '0;
    end else if (wr_en && wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_q[rd_addr_b];
    end
  end

  busy_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_busy_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// Each queued entry is checked against the outputs of the cycle in which it was pushed.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic        busy_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [31:0] busy_vec;

  typedef struct packed {
    logic [31:0] a;
    logic        ba;
    logic [31:0] b;
    logic        bb;
    logic [31:0] bv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors;
  int    miscompares;

  reg_file_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .busy_a    (busy_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every queued expectation is due at the next falling edge.
  initial begin
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = '{a: rd_data_a, ba: busy_a, b: rd_data_b, bb: busy_b, bv: busy_vec};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s: got a=%h busy_a=%b b=%h busy_b=%b busy_vec=%h, expected a=%h busy_a=%b b=%h busy_b=%b busy_vec=%h",
                   nm, got.a, got.ba, got.b, got.bb, got.bv, e.a, e.ba, e.b, e.bb, e.bv);
        end
      end
    end
  end

  task automatic step(input string nm, input logic chk,
                      input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia,
                      input logic [31:0] ea, input logic eba,
                      input logic [31:0] eb, input logic ebb, input logic [31:0] ebv);
    @(posedge clk);
    #1;
    reset      = rst;
    rd_addr_a  = ra;
    rd_addr_b  = rb;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    if (chk) begin
      exp_q.push_back('{a: ea, ba: eba, b: eb, bb: ebb, bv: ebv});
      name_q.push_back(nm);
    end
  endtask

  localparam logic [31:0] BV5  = 32'h0000_0020;
  localparam logic [31:0] BV9  = 32'h0000_0200;
  localparam logic [31:0] BV29 = 32'h2000_0200;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; rd_addr_a = '0; rd_addr_b = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; issue_en = 1'b0; issue_addr = '0;

    step("rst0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("reset_read_r%0d_r%0d", i, i + 16), 1, 0, 5'(i), 5'(i + 16),
           0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    step("write_bypass_r8",  1, 0, 8, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step("read_back_r8",     1, 0, 8, 8, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0);
    step("write_r0_bypass",  1, 0, 0, 8, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    step("issue_r0",         1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("r0_still_zero",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("issue_r5_no_byp",  1, 0, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    step("busy_r5_idle1",    1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BV5);
    step("busy_r5_both",     1, 0, 5, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, BV5);
    step("write_r5_clear",   1, 0, 5, 8, 1, 5, 32'd7, 0, 0, 32'd7, 0, 32'hDEAD_BEEF, 0, BV5);
    step("r5_after_write",   1, 0, 5, 0, 0, 0, 0, 0, 0, 32'd7, 0, 0, 0, 0);
    step("issue_wr_r9",      1, 0, 9, 0, 1, 9, 32'h55, 1, 9, 32'h55, 0, 0, 0, 0);
    step("r9_busy_after",    1, 0, 9, 9, 0, 0, 0, 0, 0, 32'h55, 1, 32'h55, 1, BV9);
    step("wr_ra_issue_sp",   1, 0, RA, SP, 1, RA, 32'hCAFE_0001, 1, SP, 32'hCAFE_0001, 0, 0, 0, BV9);
    step("ra_sp_after",      1, 0, RA, SP, 0, 0, 0, 0, 0, 32'hCAFE_0001, 0, 0, 1, BV29);
    step("reset_with_write", 0, 1, 3, 0, 1, 3, 32'd1, 1, 4, 0, 0, 0, 0, 0);
    step("after_reset_r3",   1, 0, 3, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_reset_ra",   1, 0, RA, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle",             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

MIPS general-purpose register file with an integrated busy-bit scoreboard. It is the consumer of the 5-bit write-register address chosen by the destination-select mux (rt vs rd). It holds 32×32-bit registers, serves two combinational read ports for decode, and takes one write per cycle from writeback. A per-register busy bit is set when an instruction targeting that register issues and cleared when its result is written back, so hazard logic can stall on RAW dependencies.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count = 2**ADDR_W

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_addr_a  in  ADDR_W  read port A address (rs)
- rd_data_a  out  DATA_W  read port A data
- busy_a  out  1  register at rd_addr_a has a pending write
- rd_addr_b  in  ADDR_W  read port B address (rt)
- rd_data_b  out  DATA_W  read port B data
- busy_b  out  1  register at rd_addr_b has a pending write
- wr_en  in  1  writeback write strobe
- wr_addr  in  ADDR_W  writeback destination (output of destination-select mux)
- wr_data  in  DATA_W  writeback data
- issue_en  in  1  an instruction with a destination register issues this cycle
- issue_addr  in  ADDR_W  destination of issuing instruction
- busy_vec  out  2**ADDR_W  all busy bits, registered state

## Operation
- Reset: all registers become 0 and all busy bits become 0. rd_data_* = 0, busy_* = 0, and busy_vec = 0 on the cycle after reset is sampled.
- Register 0 is hardwired:
  - It always reads 0.
  - Writes to it are ignored.
  - Issues to it are ignored, so busy_vec[0] is always 0.
- Write: if wr_en and wr_addr != 0, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the clock edge.
- Issue: if issue_en and issue_addr != 0, busy[issue_addr] <= 1 at the clock edge.
- Simultaneous issue and write to the same register: busy ends at 1, because the new producer wins. The data is still written.
- Simultaneous issue and write to different registers: both take effect independently.
- Write to a register that is not busy: the data is written and busy stays 0. This is legal and not an error.
- Reads are combinational with a write bypass:
  - If wr_en and wr_addr == rd_addr_x and rd_addr_x != 0, then rd_data_x = wr_data.
  - Otherwise rd_data_x = regs[rd_addr_x].
- Busy outputs are combinational with a write-clear bypass:
  - busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr == rd_addr_x).
  - busy_x is 0 when rd_addr_x == 0.
  - Issue is not bypassed; a register issued this cycle shows busy on the next cycle.
- Both read ports may address the same register. They return identical data and busy.
- Reset mid-operation overrides any write or issue in the same cycle.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, wr_*).
- Write latency is 1 cycle to storage; the data is visible the same cycle via the bypass.
- Busy set is visible 1 cycle after issue. Busy clear is visible the same cycle as the write.
- There is no backpressure. One write and one issue are accepted every cycle.

## Structure
- The shared MIPS package holds:
  - REG_ZERO = 5'd0
  - DATA_W / ADDR_W defaults
  - register-name constants (RA = 31, SP = 29) used by the tests
- One natural sub-module, `busy_scoreboard`. It contains the busy register array, the set/clear priority logic, and the busy_a/busy_b bypass. The storage array and read muxes stay in the top module.

## Test plan
- Reset, then read all 32 addresses: every rd_data = 0, busy = 0, busy_vec = 0.
- Write 0xDEADBEEF to r8 while rd_addr_a = 8 in the same cycle: rd_data_a = 0xDEADBEEF that cycle (bypass). The next cycle, with wr_en = 0, it still reads 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0: the result is 0. Issue to r0: busy_vec[0] stays 0.
- Issue r5, then two idle cycles: busy_a = 1 for rd_addr_a = 5. Write r5 = 7: busy_a = 0 in the write cycle, rd_data_a = 7, and busy_vec[5] = 0 on the next cycle.
- Same-cycle issue r9 and write r9 = 0x55: busy_vec[9] = 1 on the next cycle, and r9 reads 0x55.
- Write r3 = 1 with reset asserted in the same cycle: after reset, r3 reads 0 and busy_vec = 0.
